// File: rtl/tft_spi_ctrl.sv
// TFT SPI controller: panel reset pulse, ROM-driven init sequence (words and delays),
// then streamed command/pixel words. SCLK divider switches from DIV_INIT to DIV_WORK once init completes.
module tft_spi_ctrl #(
  parameter int WORD_W   = 16,
  parameter int DIV_INIT = 2500,
  parameter int DIV_WORK = 5,
  parameter int INIT_LEN = 104,
  parameter int ROM_AW   = 7,
  parameter int RST_CYC  = 50000,
  parameter int DLY_UNIT = 50000
) (
  input  logic              MasterCLK,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [WORD_W+1:0] rom_data,
  input  logic [WORD_W-1:0] px_data,
  input  logic              px_rs,
  input  logic              px_valid,
  output logic              px_ready,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  output logic              SPI_CS,
  output logic              RS,
  output logic              RST,
  output logic              init_done,
  output logic              busy
);

  localparam int DIV_MAX   = (DIV_INIT > DIV_WORK) ? DIV_INIT : DIV_WORK;
  localparam int DW        = $clog2(DIV_MAX) + 1;
  localparam int TMAX      = (RST_CYC > DLY_UNIT) ? RST_CYC : DLY_UNIT;
  localparam int TW        = $clog2(TMAX) + 1;
  localparam int HW        = $clog2(2 * WORD_W) + 1;
  localparam int LAST_ADDR = (INIT_LEN > 0) ? INIT_LEN - 1 : 0;

  typedef enum logic [2:0] {RST_LO, RST_HI, FETCH, LOAD, DELAY, SHIFT, GAP, IDLE} state_t;
  state_t state, state_nx;

  logic [TW-1:0]     tcnt;
  logic [WORD_W-1:0] dly_left;
  logic [DW-1:0]     dcnt;
  logic [DW-1:0]     div_m1;
  logic [HW-1:0]     hcnt;
  logic [WORD_W-1:0] shreg;
  logic              sclk;
  logic              rs_q;
  logic              t_rst, t_unit, t_div, last_half, last_entry;
  logic              dly_end, gap_end, entry_done;

  always_comb begin
    t_rst      = (tcnt == TW'(RST_CYC - 1));
    t_unit     = (tcnt == TW'(DLY_UNIT - 1));
    div_m1     = init_done ? DW'(DIV_WORK - 1) : DW'(DIV_INIT - 1);
    t_div      = (dcnt == div_m1);
    last_half  = (hcnt == HW'(2 * WORD_W - 1));
    last_entry = (rom_addr == ROM_AW'(LAST_ADDR));
    dly_end    = (state == DELAY) && t_unit && (dly_left == WORD_W'(1));
    gap_end    = (state == GAP) && t_div;
    entry_done = !init_done && (dly_end || gap_end);

    state_nx = state;
    case (state)
      RST_LO: if (t_rst) state_nx = RST_HI;
      RST_HI: if (t_rst) state_nx = (INIT_LEN == 0) ? IDLE : FETCH;
      FETCH:  state_nx = LOAD;
      LOAD:   state_nx = rom_data[WORD_W+1] ? DELAY : SHIFT;
      DELAY:  if (dly_end) state_nx = last_entry ? IDLE : FETCH;
      SHIFT:  if (t_div && last_half) state_nx = GAP;
      GAP:    if (t_div) state_nx = (init_done || last_entry) ? IDLE : FETCH;
      IDLE:   if (px_valid) state_nx = SHIFT;
      default: state_nx = RST_LO;
    endcase

    px_ready = (state == IDLE);
    busy     = (state != IDLE);
    RST      = (state != RST_LO);
    SPI_CS   = (state != SHIFT);
    SPI_MOSI = (state == SHIFT) && shreg[WORD_W-1];
    SPI_CLK  = sclk;
    RS       = rs_q;
  end

  // The SCLK phase counter toggles every D cycles; the shift register advances on falling edges only,
  // so the payload and RS stay frozen for the whole time SPI_CS is low.
  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      state     <= RST_LO;
      tcnt      <= '0;
      dly_left  <= '0;
      dcnt      <= '0;
      hcnt      <= '0;
      shreg     <= '0;
      sclk      <= 1'b0;
      rs_q      <= 1'b0;
      rom_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;

      if (((state == RST_LO) || (state == RST_HI)) && !t_rst) tcnt <= tcnt + 1'b1;
      else if ((state == DELAY) && !t_unit)                   tcnt <= tcnt + 1'b1;
      else                                                     tcnt <= '0;

      if (state == LOAD)
        dly_left <= (rom_data[WORD_W-1:0] == '0) ? WORD_W'(1) : rom_data[WORD_W-1:0];
      else if ((state == DELAY) && t_unit)
        dly_left <= dly_left - 1'b1;

      if (((state == SHIFT) || (state == GAP)) && !t_div) dcnt <= dcnt + 1'b1;
      else                                                 dcnt <= '0;

      if ((state == SHIFT) && t_div) begin
        hcnt <= last_half ? '0 : hcnt + 1'b1;
        sclk <= last_half ? 1'b0 : ~sclk;
      end

      if ((state == LOAD) && !rom_data[WORD_W+1]) begin
        shreg <= rom_data[WORD_W-1:0];
        rs_q  <= rom_data[WORD_W];
      end else if ((state == IDLE) && px_valid) begin
        shreg <= px_data;
        rs_q  <= px_rs;
      end else if ((state == SHIFT) && t_div && sclk) begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
      end

      // The address stops on the last entry instead of wrapping.
      if (entry_done && !last_entry) rom_addr <= rom_addr + 1'b1;
      if (state_nx == IDLE) init_done <= 1'b1;
    end
  end

endmodule
